// File: rtl/dc_ipu_shr_pipeline_pkg.sv
// Shared types and constants for the IPU skid-buffer stage control.
package dc_ipu_shr_pipeline_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    function automatic logic [OCC_W-1:0] state_occ(input pipe_state_e s);
        case (s)
            PS_EMPTY: return OCC_W'(0);
            PS_ONE:   return OCC_W'(1);
            PS_TWO:   return OCC_W'(2);
            default:  return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/dc_ipu_shr_sat_counter.sv
// Saturating up-counter with synchronous clear; built only when
// DC_IPU_PIPELINE_STALL_CNT_EN is defined.
module dc_ipu_shr_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dc_ipu_shr_pipeline_ctrl.sv
// Valid/ready control for one skid-buffer stage (main + side register).
// Optional stall counter: define DC_IPU_PIPELINE_STALL_CNT_EN.
module dc_ipu_shr_pipeline_ctrl
    import dc_ipu_shr_pipeline_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic                   buf_main_en,
    output logic                   buf_side_en,
    output logic                   buf_restore,
    output logic [OCC_W-1:0]       occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_e      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [OCC_W-1:0] occ_q;
    logic             acc, pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        buf_main_en = 1'b0;
        buf_side_en = 1'b0;
        buf_restore = 1'b0;
        case (state_q)
            PS_EMPTY: begin
                if (acc) begin
                    buf_main_en = 1'b1;
                    state_d     = PS_ONE;
                end
            end
            PS_ONE: begin
                if (acc && pop) begin
                    buf_main_en = 1'b1;
                end else if (acc) begin
                    buf_side_en = 1'b1;
                    state_d     = PS_TWO;
                end else if (pop) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_TWO: begin
                // in_ready is low here, so only a pop can move the stage
                if (pop) begin
                    buf_main_en = 1'b1;
                    buf_restore = 1'b1;
                    state_d     = PS_ONE;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
        if (flush) begin
            state_d     = PS_EMPTY;
            buf_main_en = 1'b0;
            buf_side_en = 1'b0;
            buf_restore = 1'b0;
        end
    end

    // Status outputs are registered from the next state so no ready path crosses the stage.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= PS_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != PS_TWO);
            out_valid_q <= (state_d != PS_EMPTY);
            occ_q       <= state_occ(state_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occ_q;

`ifdef DC_IPU_PIPELINE_STALL_CNT_EN
    logic stall_inc;

    assign stall_inc = out_valid_q & ~out_ready;

    dc_ipu_shr_sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (flush),
        .inc    (stall_inc),
        .cnt    (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dc_ipu_shr_pipeline_ctrl.sv
// Bench for dc_ipu_shr_pipeline_ctrl: a data buffer driven by the DUT strobes
// is checked against a scoreboard queue and a 2-deep occupancy model.
module tb_dc_ipu_shr_pipeline_ctrl;

    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic         in_ready, out_valid, buf_main_en, buf_side_en, buf_restore;
    logic [1:0]   occupancy;
    logic [W-1:0] stall_cnt;

    int           checks = 0;
    int           errors = 0;

    int           held = 0;
    logic [W-1:0] m_stall = '0;
    logic [7:0]   d = 8'd0, next_data = 8'd0, buf_main = 8'd0, buf_side = 8'd0;
    logic [7:0]   sb[$];
    logic         e_acc, e_pop, e_main, e_side, e_rest;

    always #5 clk = ~clk;

    dc_ipu_shr_pipeline_ctrl #(
        .STALL_CNT_W (W)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .buf_main_en (buf_main_en),
        .buf_side_en (buf_side_en),
        .buf_restore (buf_restore),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt)
    );

    function automatic logic [W-1:0] exp_stall(input int v);
`ifdef DC_IPU_PIPELINE_STALL_CNT_EN
        return (v > 3) ? W'(3) : W'(v);
`else
        return (v >= 0) ? '0 : '0;
`endif
    endfunction

    // Expected strobes derived from the held-entry count.
    task automatic settle();
        @(negedge clk);
        e_acc  = in_valid && (held != 2);
        e_pop  = (held != 0) && out_ready;
        e_main = !flush && ((e_acc && (held == 0 || e_pop)) || (e_pop && held == 2));
        e_side = !flush && e_acc && !e_pop && (held == 1);
        e_rest = !flush && e_pop && (held == 2);
    endtask

    task automatic advance();
        if (buf_main_en) buf_main = buf_restore ? buf_side : d;
        if (buf_side_en) buf_side = d;
        if (e_pop && sb.size() > 0) void'(sb.pop_front());
        if (e_acc) sb.push_back(d);
        if (flush) m_stall = '0;
        else if (held != 0 && !out_ready && m_stall != {W{1'b1}}) m_stall = m_stall + W'(1);
        held = flush ? 0 : held + int'(e_acc) - int'(e_pop);
        if (flush) sb.delete();
        next_data = next_data + 8'd1;
        @(posedge clk);
        #1;
        d = next_data;
    endtask

    task automatic model_reset();
        held = 0;
        m_stall = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        model_reset();
        d = next_data;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 9; i++) begin
            in_valid  = (i < 8);
            out_ready = 1'b1;
            settle();
            checks++;
            if (buf_main_en !== (i < 8)) begin
                errors++; $display("FAIL stream_main_en cyc %0d got %b want %b", i, buf_main_en, i < 8);
            end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc %0d got %b want 1", i, in_ready); end
            if (i > 0) begin
                checks++;
                if (occupancy !== 2'd1 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL stream_occ cyc %0d got %0d/%b want 1/1", i, occupancy, out_valid);
                end
                checks++;
                if (sb.size() == 0 || buf_main !== sb[0]) begin
                    errors++; $display("FAIL stream_data cyc %0d got %h want %h", i, buf_main, (sb.size() > 0) ? sb[0] : 8'hxx);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        int side_pulses = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid  = (k < 5);
            out_ready = (k == 0 || k >= 4);
            settle();
            if (buf_side_en) side_pulses++;
            if (k >= 1 && k <= 3) begin
                checks++;
                if (in_ready !== (k == 1)) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b want %b", k, in_ready, k == 1); end
                checks++;
                if (occupancy !== ((k == 1) ? 2'd1 : 2'd2)) begin
                    errors++; $display("FAIL stall_occ cyc %0d got %0d want %0d", k, occupancy, (k == 1) ? 1 : 2);
                end
            end
            if (k == 4) begin
                checks++;
                if ({buf_main_en, buf_side_en, buf_restore} !== 3'b101) begin
                    errors++; $display("FAIL stall_restore got %b want 101", {buf_main_en, buf_side_en, buf_restore});
                end
            end
            if (k == 5) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got %b want 1", in_ready); end
            end
            if (k >= 4) begin
                checks++;
                if (sb.size() == 0 || buf_main !== sb[0]) begin
                    errors++; $display("FAIL stall_data cyc %0d got %h want %h", k, buf_main, (sb.size() > 0) ? sb[0] : 8'hxx);
                end
            end
            advance();
        end
        checks++;
        if (side_pulses != 1) begin errors++; $display("FAIL stall_side_pulses got %0d want 1", side_pulses); end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain got %0d left/%b want 0/0", sb.size(), out_valid);
        end
    endtask

    task automatic test_stall_cnt();
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        settle(); advance();
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        settle(); advance();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b0;
            settle();
            if (k > 0) begin
                checks++;
                if (stall_cnt !== exp_stall(k)) begin
                    errors++; $display("FAIL stall_cnt step %0d got %0d want %0d", k, stall_cnt, exp_stall(k));
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0;
        settle(); advance();
        checks++;
        if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
        flush = 1'b1;
        settle();
        checks++;
        if ({buf_main_en, buf_side_en, buf_restore} !== 3'b000) begin
            errors++; $display("FAIL flush_strobes got %b want 000", {buf_main_en, buf_side_en, buf_restore});
        end
        advance();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
            errors++; $display("FAIL flush_state got %b want 0100", {out_valid, in_ready, occupancy});
        end
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL flush_stall got %0d want 0", stall_cnt); end
        advance();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b0;
        settle(); advance();
        settle(); advance();
        #1;
        nreset = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
            errors++; $display("FAIL reset_mid got %b want 0100", {out_valid, in_ready, occupancy});
        end
        model_reset();
        in_valid = 1'b0;
        nreset = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            settle();
            checks++;
            if ({buf_main_en, buf_side_en, buf_restore} !== {e_main, e_side, e_rest}) begin
                errors++; $display("FAIL rnd_strobes cyc %0d got %b want %b", i,
                    {buf_main_en, buf_side_en, buf_restore}, {e_main, e_side, e_rest});
            end
            checks++;
            if (buf_main_en && buf_side_en) begin errors++; $display("FAIL rnd_excl cyc %0d got 11 want not both", i); end
            checks++;
            if ({in_ready, out_valid, occupancy} !== {held != 2, held != 0, 2'(held)}) begin
                errors++; $display("FAIL rnd_status cyc %0d got %b want %b", i,
                    {in_ready, out_valid, occupancy}, {held != 2, held != 0, 2'(held)});
            end
            checks++;
`ifdef DC_IPU_PIPELINE_STALL_CNT_EN
            if (stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", i, stall_cnt, m_stall); end
`else
            if (stall_cnt !== '0) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d want 0", i, stall_cnt); end
`endif
            if (e_pop) begin
                checks++;
                if (sb.size() == 0 || buf_main !== sb[0]) begin
                    errors++; $display("FAIL rnd_data cyc %0d got %h want %h", i, buf_main, (sb.size() > 0) ? sb[0] : 8'hxx);
                end
            end
            advance();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_stall_cnt();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
